bcd_to_bin_seq: RTL and testbench
=================================

# bcd_to_bin_seq

Sequential BCD-to-binary converter, the inverse of the display path that splits a binary switch value into decimal digits for the seven-segment decoders. It accepts a packed multi-digit BCD value (keypad or switch digit entry) and produces the equivalent unsigned binary value using reverse double-dabble, one shift per clock. It sits between digit-entry logic and any arithmetic or LED consumer, with a start/busy/done handshake.

## Interface

- DIGITS, 2, number of BCD digits in `bcd`; digit 0 is `bcd[3:0]` (ones).
- BIN_W, 7, output width; must satisfy 2^BIN_W >= 10^DIGITS (DIGITS=2 → 7, DIGITS=3 → 10).

- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd  input  4*DIGITS  packed BCD operand, sampled on the accepted `start` edge only.
- busy  output  1  high from the cycle after acceptance until `done` is high.
- done  output  1  one-cycle pulse; `bin`/`err` valid from this cycle.
- bin  output  BIN_W  converted value; held until the next `done`.
- err  output  1  invalid-digit flag for the last conversion; held until the next `done`.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE: `busy`=0. On `start`=1, latch `bcd` into the digit register, clear the binary shift register, load counter = BIN_W, go to SHIFT (or DONE with error, see Configuration).
- SHIFT: each cycle, shift the concatenation {digits, binary} right by one bit; then, for each digit independently, if digit >= 8 subtract 3. Decrement the counter; after BIN_W shifts go to DONE.
- DONE: copy binary register to `bin`, set `err`, pulse `done`=1, deassert `busy`, return to IDLE next cycle.
- `start` while busy or in DONE is ignored, not queued. `start` held high continuously re-triggers on every IDLE cycle.
- `bcd` changes after acceptance have no effect on the running conversion.
- Arithmetic: all digit adjustments are 4-bit unsigned; the binary register is exactly BIN_W bits; no value wider than 10^DIGITS-1 is possible with valid input.

## Timing

- Reset values: `bin`=0, `err`=0, `done`=0, `busy`=0, state IDLE, counter 0.
- `start` accepted at edge N → `busy`=1 from N+1, `done`=1 on the cycle after edge N+BIN_W+1 (latency BIN_W+1 cycles; 8 for defaults), `busy`=0 in that same cycle.
- Back-to-back: `start` high in the cycle following `done` is accepted; maximum throughput one conversion per BIN_W+2 cycles.
- Reset mid-conversion: immediate abort to reset values; no `done` pulse generated for the aborted operation.
- `bin` and `err` change only in the `done` cycle.

## Configuration

- `BCD_TO_BIN_CHECK_EN` defined: on acceptance, any digit > 9 skips SHIFT and goes directly to DONE (`done` one cycle after acceptance), with `bin`=0 and `err`=1. Valid input gives `err`=0.
- Not defined: no digit check; `err` tied 0; invalid digits run the full SHIFT sequence and `bin` is whatever the algorithm produces (deterministic, not specified).

## Test plan

- Reset then idle: `rst` pulse, no `start` → `bin`=0, `err`=0, `busy`=0, `done` never high.
- Single conversion: `bcd`=8'h42, `start` one cycle → `busy` for 7 cycles, `done` on 8th cycle, `bin`=42, `err`=0.
- Boundaries: `bcd`=8'h00 → `bin`=0; `bcd`=8'h99 → `bin`=99; `bcd`=8'h10 → `bin`=10; all with 8-cycle latency.
- Invalid digit with `BCD_TO_BIN_CHECK_EN`: `bcd`=8'h3A → `done` 1 cycle after acceptance, `bin`=0, `err`=1; next `bcd`=8'h07 → `bin`=7, `err`=0.
- Ignore during busy: `start` with 8'h25, second `start` with 8'h63 at cycle 3 → only one `done`, `bin`=25; `start` held high → conversions every 9 cycles.
- Abort: start 8'h77, assert `rst` at cycle 4 → all outputs 0 immediately, no `done`; fresh start 8'h31 → `bin`=31.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift/clk).
// Optional digit validity check: define BCD_TO_BIN_CHECK_EN.
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);

  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state, state_nx;
  logic [4*DIGITS-1:0] dig_q, dig_sh, dig_adj;
  logic [BIN_W-1:0]    bin_q, bin_sh, bin_r;
  logic [CW-1:0]       cnt_q;
  logic                err_r;
  logic                bad;
  logic                last;

  // Shift {digits, binary} right by one, then pull each digit >= 8 down by 3
  always_comb begin
    dig_sh  = dig_q >> 1;
    bin_sh  = {dig_q[0], bin_q[BIN_W-1:1]};
    dig_adj = dig_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_sh[4*i+3])
        dig_adj[4*i+:4] = dig_sh[4*i+:4] - 4'd3;
    end
  end

`ifdef BCD_TO_BIN_CHECK_EN
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i+:4] > 4'd9)
        bad = 1'b1;
    end
  end
`else
  assign bad = 1'b0;
`endif

  assign last = (cnt_q == CW'(1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = bad ? DONE : SHIFT;
      SHIFT: if (last)  state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dig_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      bin_r <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            dig_q <= bcd;
            bin_q <= '0;
            cnt_q <= CW'(BIN_W);
            if (bad) begin
              bin_r <= '0;
              err_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          dig_q <= dig_adj;
          bin_q <= bin_sh;
          cnt_q <= cnt_q - 1'b1;
          // Result is published on the edge entering DONE
          if (last) begin
            bin_r <= bin_sh;
            err_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign bin  = bin_r;
  assign err  = err_r;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: vector table plus
// hand-written sequences for ignore, re-trigger and abort behaviour.
module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bcd = 8'h00;
  logic       busy, done, err;
  logic [6:0] bin;

  int ncmp = 0;
  int nfail = 0;

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] bin;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One conversion: pulse start, scramble bcd after acceptance,
  // check busy/held bin each cycle, then latency and result.
  task automatic run(input logic [7:0] v, input logic [6:0] eb,
                     input logic ee, input int lat, input logic cb,
                     input string nm);
    int k;
    logic [6:0] held;
    held = bin;
    @(negedge clk);
    bcd = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd = ~v;
    k = 1;
    while (!done && k < 20) begin
      chk({nm, " busy"}, int'(busy), 1);
      chk({nm, " held"}, int'(bin), int'(held));
      @(negedge clk);
      k++;
    end
    chk({nm, " done"}, int'(done), 1);
    chk({nm, " latency"}, k, lat);
    chk({nm, " busy@done"}, int'(busy), 0);
    if (cb) chk({nm, " bin"}, int'(bin), int'(eb));
    chk({nm, " err"}, int'(err), int'(ee));
    @(negedge clk);
    chk({nm, " done pulse"}, int'(done), 0);
  endtask

  initial begin
    int nd;
    int t [3];

    vecs[0] = '{8'h42, 7'd42};
    vecs[1] = '{8'h00, 7'd0};
    vecs[2] = '{8'h99, 7'd99};
    vecs[3] = '{8'h10, 7'd10};
    vecs[4] = '{8'h07, 7'd7};
    vecs[5] = '{8'h55, 7'd55};
    vecs[6] = '{8'h81, 7'd81};
    vecs[7] = '{8'h19, 7'd19};
    vecs[8] = '{8'h90, 7'd90};

    // Reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst bin", int'(bin), 0);
    chk("rst err", int'(err), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst no done", nd, 0);

    for (int i = 0; i < 9; i++)
      run(vecs[i].bcd, vecs[i].bin, 1'b0, 8, 1'b1,
          $sformatf("vec%0d", i));

    // Invalid digit
`ifdef BCD_TO_BIN_CHECK_EN
    run(8'h3A, 7'd0, 1'b1, 1, 1'b1, "inv3A");
`else
    run(8'h3A, 7'd0, 1'b0, 8, 1'b0, "inv3A");
`endif
    run(8'h07, 7'd7, 1'b0, 8, 1'b1, "after inv");

    // Second start while busy is ignored
    @(negedge clk);
    bcd = 8'h25;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        bcd = 8'h63;
        start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        nd++;
        chk("ign latency", k, 8);
        chk("ign bin", int'(bin), 25);
      end
      @(negedge clk);
    end
    chk("ign one done", nd, 1);

    // Start held high re-triggers every BIN_W+2 cycles
    bcd = 8'h58;
    start = 1'b1;
    nd = 0;
    for (int k = 0; k < 40 && nd < 3; k++) begin
      @(negedge clk);
      if (done) begin
        t[nd] = k;
        chk($sformatf("hold bin%0d", nd), int'(bin), 58);
        nd++;
      end
    end
    start = 1'b0;
    chk("hold dones", nd, 3);
    if (nd == 3) begin
      chk("hold period1", t[1] - t[0], 9);
      chk("hold period2", t[2] - t[1], 9);
    end
    repeat (10) @(negedge clk);

    // Asynchronous abort mid-conversion
    bcd = 8'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort bin", int'(bin), 0);
    chk("abort err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort quiet", nd, 0);
    run(8'h31, 7'd31, 1'b0, 8, 1'b1, "post abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
